// File: rtl/decode_stage.sv
// decode_stage: RV32 instruction decode with a 2-entry skid buffer of
// decoded bundles. Decode is combinational on the incoming word; the result
// is captured when the input handshake completes. All outputs come straight
// from registers.
module decode_stage #(
    parameter int XLEN          = 32,
    parameter int ILLEGAL_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instruction,
    input  logic [XLEN-1:0]          pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [6:0]               opcode,
    output logic [2:0]               funct3,
    output logic [6:0]               funct7,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [4:0]               rd,
    output logic [XLEN-1:0]          imm,
    output logic [2:0]               imm_type,
    output logic                     illegal,
    output logic [ILLEGAL_CNT_W-1:0] illegal_count
);

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [2:0]      imm_type;
        logic            illegal;
    } bundle_t;

    // Builds a full decoded bundle; raw fields are always passed through,
    // unknown encodings get a zero immediate and the illegal flag.
    function automatic bundle_t decode_inst(input logic [31:0] inst, input logic [XLEN-1:0] addr);
        bundle_t     b;
        logic [31:0] imm32;
        b.pc       = addr;
        b.opcode   = inst[6:0];
        b.funct3   = inst[14:12];
        b.funct7   = inst[31:25];
        b.rs1      = inst[19:15];
        b.rs2      = inst[24:20];
        b.rd       = inst[11:7];
        b.imm_type = IMM_NONE;
        b.illegal  = 1'b0;
        imm32      = 32'd0;
        if (inst[1:0] != 2'b11) begin
            b.illegal = 1'b1;
        end else begin
            case (inst[6:0])
                7'b0000011, 7'b0010011, 7'b1100111: begin
                    imm32      = {{20{inst[31]}}, inst[31:20]};
                    b.imm_type = IMM_I;
                end
                7'b0100011: begin
                    imm32      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                    b.imm_type = IMM_S;
                end
                7'b1100011: begin
                    imm32      = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                    b.imm_type = IMM_B;
                end
                7'b0110111, 7'b0010111: begin
                    imm32      = {inst[31:12], 12'd0};
                    b.imm_type = IMM_U;
                end
                7'b1101111: begin
                    imm32      = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                    b.imm_type = IMM_J;
                end
                7'b0110011, 7'b0001111, 7'b1110011: begin
                    imm32      = 32'd0;
                    b.imm_type = IMM_NONE;
                end
                default: begin
                    imm32      = 32'd0;
                    b.imm_type = IMM_NONE;
                    b.illegal  = 1'b1;
                end
            endcase
        end
        // Every 32-bit immediate above is already sign-correct; widen by
        // replicating bit 31 for 64-bit datapaths.
        b.imm = XLEN'($signed(imm32));
        return b;
    endfunction

    bundle_t                  decoded_s;
    bundle_t                  head_r;
    bundle_t                  skid_r;
    bundle_t                  head_n_s;
    bundle_t                  skid_n_s;
    logic [1:0]               count_r;
    logic [1:0]               count_n_s;
    logic                     out_valid_r;
    logic                     in_ready_r;
    logic                     push_s;
    logic                     pop_s;
    logic [ILLEGAL_CNT_W-1:0] illegal_count_r;
    logic [ILLEGAL_CNT_W-1:0] illegal_count_n_s;

    assign decoded_s = decode_inst(instruction, pc);
    assign push_s    = in_valid & in_ready_r;
    assign pop_s     = out_valid_r & out_ready;

    // Buffer occupancy and entry movement for the next cycle.
    always_comb begin
        count_n_s = count_r;
        head_n_s  = head_r;
        skid_n_s  = skid_r;
        if (flush) begin
            count_n_s = 2'd0;
        end else begin
            case (count_r)
                2'd0: begin
                    if (push_s) begin
                        head_n_s  = decoded_s;
                        count_n_s = 2'd1;
                    end else begin
                        count_n_s = 2'd0;
                    end
                end
                2'd1: begin
                    if (push_s && pop_s) begin
                        head_n_s  = decoded_s;
                        count_n_s = 2'd1;
                    end else if (push_s) begin
                        skid_n_s  = decoded_s;
                        count_n_s = 2'd2;
                    end else if (pop_s) begin
                        count_n_s = 2'd0;
                    end else begin
                        count_n_s = 2'd1;
                    end
                end
                2'd2: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop_s) begin
                        head_n_s  = skid_r;
                        count_n_s = 2'd1;
                    end else begin
                        count_n_s = 2'd2;
                    end
                end
                default: begin
                    count_n_s = 2'd0;
                end
            endcase
        end
    end

    // Saturating count of illegal bundles handed to the consumer.
    always_comb begin
        illegal_count_n_s = illegal_count_r;
        if (pop_s && head_r.illegal && (illegal_count_r != {ILLEGAL_CNT_W{1'b1}})) begin
            illegal_count_n_s = illegal_count_r + ILLEGAL_CNT_W'(1'b1);
        end else begin
            illegal_count_n_s = illegal_count_r;
        end
    end

    // State registers; ready/valid are registered from the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r         <= 2'd0;
            out_valid_r     <= 1'b0;
            in_ready_r      <= 1'b1;
            head_r          <= '0;
            skid_r          <= '0;
            illegal_count_r <= '0;
        end else begin
            count_r         <= count_n_s;
            out_valid_r     <= (count_n_s != 2'd0);
            in_ready_r      <= (count_n_s != 2'd2);
            head_r          <= head_n_s;
            skid_r          <= skid_n_s;
            illegal_count_r <= illegal_count_n_s;
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign out_pc        = head_r.pc;
    assign opcode        = head_r.opcode;
    assign funct3        = head_r.funct3;
    assign funct7        = head_r.funct7;
    assign rs1           = head_r.rs1;
    assign rs2           = head_r.rs2;
    assign rd            = head_r.rd;
    assign imm           = head_r.imm;
    assign imm_type      = head_r.imm_type;
    assign illegal       = head_r.illegal;
    assign illegal_count = illegal_count_r;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a table of instruction vectors with expected
// immediates/types pushed to a scoreboard on input handshakes and compared
// on output handshakes, plus directed backpressure/flush/reset sequences.
module tb_decode_stage;
    localparam int XLEN = 32;
    localparam int CW   = 3;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, out_ready;
    logic            in_ready, out_valid, illegal;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pc, out_pc, imm;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3, imm_type;
    logic [4:0]      rs1, rs2, rd;
    logic [CW-1:0]   illegal_count;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .ILLEGAL_CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1),
        .rs2(rs2), .rd(rd), .imm(imm), .imm_type(imm_type), .illegal(illegal),
        .illegal_count(illegal_count)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  itype;
        logic        ill;
    } rec_t;

    rec_t          vecs[16];
    rec_t          sb[$];
    rec_t          cur;
    rec_t          mon_e;
    int            checks = 0;
    int            fails  = 0;
    logic [CW-1:0] cnt_model = '0;
    bit            rand_ready = 1'b0;
    logic [31:0]   pc_ctr = 32'h0000_1000;
    logic [99:0]   act_bundle;

    assign act_bundle = {out_pc, opcode, funct3, funct7, rs1, rs2, rd, imm, imm_type, illegal};

    function automatic logic [99:0] pack_exp(input rec_t r);
        return {r.pc, r.inst[6:0], r.inst[14:12], r.inst[31:25], r.inst[19:15],
                r.inst[24:20], r.inst[11:7], r.imm, r.itype, r.ill};
    endfunction

    function automatic rec_t v(input logic [31:0] inst, input logic [31:0] im,
                               input logic [2:0] t, input logic il);
        rec_t r;
        r.inst  = inst;
        r.pc    = pc_ctr;
        r.imm   = im;
        r.itype = t;
        r.ill   = il;
        pc_ctr  = pc_ctr + 32'd4;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: samples the handshakes that will occur at the next rising edge.
    always @(negedge clk) begin
        check("illegal_count", {125'd0, illegal_count}, {125'd0, cnt_model});
        if (rst) begin
            sb.delete();
            cnt_model = '0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_output: actual pc %0h required no bundle", out_pc);
                end else begin
                    mon_e = sb.pop_front();
                    check("bundle", {28'd0, act_bundle}, {28'd0, pack_exp(mon_e)});
                    if (mon_e.ill && (cnt_model != {CW{1'b1}})) cnt_model = cnt_model + 3'd1;
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(cur);
        end
    end

    task automatic present(input rec_t r);
        cur         = r;
        in_valid    = 1'b1;
        instruction = r.inst;
        pc          = r.pc;
    endtask

    task automatic send(input rec_t r);
        int   n;
        logic acc;
        present(r);
        n = 0;
        do begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: actual not accepted required accept within 50 cycles");
        end
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 128'(sb.size()), 128'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instruction = 32'd0; pc = '0;

        vecs[0]  = v(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0); // addi x1,x0,-1
        vecs[1]  = v(32'h00112623, 32'h0000000C, 3'd2, 1'b0); // sw x1,12(x2)
        vecs[2]  = v(32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0); // beq x0,x0,-4
        vecs[3]  = v(32'h123452B7, 32'h12345000, 3'd4, 1'b0); // lui x5,0x12345
        vecs[4]  = v(32'h008000EF, 32'h00000008, 3'd5, 1'b0); // jal x1,8
        vecs[5]  = v(32'h00000000, 32'h00000000, 3'd0, 1'b1);
        vecs[6]  = v(32'hFFFFFFFF, 32'h00000000, 3'd0, 1'b1);
        vecs[7]  = v(32'h00A30333, 32'h00000000, 3'd0, 1'b0); // add
        vecs[8]  = v(32'h0000000F, 32'h00000000, 3'd0, 1'b0); // fence
        vecs[9]  = v(32'h00000073, 32'h00000000, 3'd0, 1'b0); // ecall
        vecs[10] = v(32'h80002003, 32'hFFFFF800, 3'd1, 1'b0); // lw min offset
        vecs[11] = v(32'h80000017, 32'h80000000, 3'd4, 1'b0); // auipc sign bit
        vecs[12] = v(32'hFFC08067, 32'hFFFFFFFC, 3'd1, 1'b0); // jalr
        vecs[13] = v(32'h00000002, 32'h00000000, 3'd0, 1'b1); // compressed
        vecs[14] = v(32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0); // sw -4
        vecs[15] = v(32'h0000005B, 32'h00000000, 3'd0, 1'b1); // unlisted opcode

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_in_ready", 128'(in_ready), 128'd1);
        check("reset_bundle", {28'd0, act_bundle}, 128'd0);

        // Single-cycle latency with an empty buffer.
        out_ready = 1'b1;
        send(v(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0));
        in_valid = 1'b0;
        check("latency_valid", 128'(out_valid), 128'd1);
        @(posedge clk);
        #1;
        check("latency_drained", 128'(out_valid), 128'd0);

        // Vector table under random consumer backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(vecs[i]);
        rand_ready = 1'b0;
        drain();

        // Backpressure: A,B fill the buffer, C waits, then all drain in order.
        out_ready = 1'b0;
        send(v(32'h00100093, 32'h00000001, 3'd1, 1'b0));
        send(v(32'h00200113, 32'h00000002, 3'd1, 1'b0));
        check("full_in_ready", 128'(in_ready), 128'd0);
        check("full_out_valid", 128'(out_valid), 128'd1);
        present(v(32'h00300193, 32'h00000003, 3'd1, 1'b0));
        @(posedge clk);
        #1;
        check("c_held_in_ready", 128'(in_ready), 128'd0);
        out_ready = 1'b1;
        send(cur);
        drain();

        // Flush with two entries held, then with one held and input accepted.
        out_ready = 1'b0;
        send(v(32'h00400213, 32'h00000004, 3'd1, 1'b0));
        send(v(32'h00500293, 32'h00000005, 3'd1, 1'b0));
        present(v(32'h00600313, 32'h00000006, 3'd1, 1'b0));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush2_out_valid", 128'(out_valid), 128'd0);
        check("flush2_in_ready", 128'(in_ready), 128'd1);
        send(v(32'h00700393, 32'h00000007, 3'd1, 1'b0));
        present(v(32'h00800413, 32'h00000008, 3'd1, 1'b0));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush1_out_valid", 128'(out_valid), 128'd0);
        check("flush1_in_ready", 128'(in_ready), 128'd1);
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("flush_no_output", 128'(out_valid), 128'd0);

        // Counter saturation: 4 illegal so far, 5 more must stop at all-ones.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(v(32'h0000005B | (i << 7), 32'd0, 3'd0, 1'b1));
        drain();
        check("illegal_count_sat", 128'(illegal_count), 128'd7);

        // Reset mid-operation with two held and an illegal head ready to leave.
        out_ready = 1'b0;
        send(v(32'h00000000, 32'd0, 3'd0, 1'b1));
        send(v(32'h00900493, 32'h00000009, 3'd1, 1'b0));
        present(v(32'h00A00513, 32'h0000000A, 3'd1, 1'b0));
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_illegal_count", 128'(illegal_count), 128'd0);
        check("rst_bundle", {28'd0, act_bundle}, 128'd0);
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("rst_no_output", 128'(out_valid), 128'd0);

        // Two illegal words from a cleared counter.
        send(v(32'h00000000, 32'd0, 3'd0, 1'b1));
        send(v(32'hFFFFFFFF, 32'd0, 3'd0, 1'b1));
        drain();
        check("illegal_count_two", 128'(illegal_count), 128'd2);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: XLEN, default 32, immediate/pc datapath width; legal values 32 or 64.
REQ-002 Parameter: ILLEGAL_CNT_W, default 16, width of the illegal-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard all buffered instructions.
REQ-006 in_valid  input  1  instruction/pc presented.
REQ-007 in_ready  output  1  stage can accept this cycle.
REQ-008 instruction  input  32  raw RV32 instruction word.
REQ-009 pc  input  XLEN  address of instruction.
REQ-010 out_valid  output  1  decoded bundle valid.
REQ-011 out_ready  input  1  consumer accepts bundle.
REQ-012 out_pc  output  XLEN  pc of bundle.
REQ-013 opcode/funct3/funct7/rs1/rs2/rd  output  7/3/7/5/5/5  raw fields of bundle instruction.
REQ-014 imm  output  XLEN  sign-extended immediate.
REQ-015 imm_type  output  3  0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J.
REQ-016 illegal  output  1  bundle instruction not recognised.
REQ-017 illegal_count  output  ILLEGAL_CNT_W  count of illegal bundles delivered.

Function
REQ-018 Handshake: transfer on in side when in_valid&in_ready; on out side when out_valid&out_ready.
REQ-019 Storage: 2-entry skid FIFO of decoded bundles (main + skid); decode is combinational on input, result registered at acceptance.
REQ-020 Latency: instruction accepted in cycle N appears on out_valid in cycle N+1 when buffer empty.
REQ-021 in_ready = 1 when fewer than 2 entries are held; 0 when both held (registered, not combinational on out_ready).
REQ-022 Simultaneous accept and deliver with 1 entry held: occupancy stays 1, new bundle becomes head next cycle.
REQ-023 Ordering strictly FIFO; no bundle dropped or duplicated under any valid/ready pattern.
REQ-024 Outputs while out_valid=1 remain stable until accepted.
REQ-025 Immediate I-type (opcodes 0000011, 0010011, 1100111): sext(inst[31:20]).
REQ-026 S-type (0100011): sext({inst[31:25],inst[11:7]}).
REQ-027 B-type (1100011): sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
REQ-028 U-type (0110111, 0010111): sext({inst[31:12],12'b0}).
REQ-029 J-type (1101111): sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
REQ-030 R-type (0110011), 0001111, 1110011: imm=0, imm_type=0.
REQ-031 Sign extension replicates inst[31] up to bit XLEN-1 for all non-zero formats.
REQ-032 illegal=1 when inst[1:0]!=2'b11 or opcode not listed in REQ-025..030; then imm=0, imm_type=0, fields still passed raw.
REQ-033 illegal_count increments by 1 on each out-side transfer with illegal=1; saturates at all-ones.
REQ-034 flush: next cycle occupancy=0, out_valid=0, in_ready=1; an input handshake in the flush cycle is discarded; illegal_count unaffected.
REQ-035 Stage contains no simulation-only display output.

Reset
REQ-036 rst has priority over flush and handshakes.
REQ-037 After reset: out_valid=0, in_ready=1, occupancy=0, illegal_count=0, all bundle outputs 0.
REQ-038 Reset mid-operation discards held bundles; no transfer counted in the reset cycle.

Verification
REQ-039 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, rd=1, imm_type=1, imm=0xFFFFFFFF (XLEN=32) / all-ones (XLEN=64).
REQ-040 0x00112623 (sw x1,12(x2)) -> imm=12, imm_type=2, rs1=2, rs2=1; 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, imm_type=3.
REQ-041 0x123452B7 (lui x5,0x12345) -> imm=0x12345000, rd=5, imm_type=4; 0x008000EF (jal x1,8) -> imm=8, imm_type=5.
REQ-042 out_ready=0, send A,B,C back-to-back -> A,B accepted, in_ready=0 from cycle after B, C held; release out_ready -> A,B,C delivered in order, none lost.
REQ-043 Deliver 0x00000000 then 0xFFFFFFFF -> both illegal=1, imm=0, illegal_count=2; preset count near all-ones -> saturates.
REQ-044 Two bundles held, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and flush-cycle input never appear; rst same scenario -> REQ-037 state.
